// File: rtl/axi_uartlite_responder_pkg.sv
// UART-Lite register offsets, status bit layout and AXI response codes.
// Shared by the responder top and its byte FIFO; no logic of its own beyond the status packer.
package axi_uartlite_responder_pkg;

  localparam logic [1:0] UART_RX   = 2'd0;
  localparam logic [1:0] UART_TX   = 2'd1;
  localparam logic [1:0] UART_STAT = 2'd2;
  localparam logic [1:0] UART_CTRL = 2'd3;

  localparam int STAT_RX_NE    = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_OVERRUN  = 5;

  localparam int CTRL_CLR_TX = 0;
  localparam int CTRL_CLR_RX = 1;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic [31:0] stat_word(input logic rx_ne, input logic rx_full,
                                            input logic tx_empty, input logic tx_full,
                                            input logic ovr);
    logic [31:0] w;
    w                = '0;
    w[STAT_RX_NE]    = rx_ne;
    w[STAT_RX_FULL]  = rx_full;
    w[STAT_TX_EMPTY] = tx_empty;
    w[STAT_TX_FULL]  = tx_full;
    w[STAT_OVERRUN]  = ovr;
    return w;
  endfunction

endpackage

// File: rtl/axi_uartlite_responder_byte_fifo.sv
// Byte FIFO, head visible combinationally; push/pop take effect on the clock edge.
// Push while full is dropped unless a pop frees the slot that cycle; clear overrides push and pop.
module axi_uartlite_responder_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  input  logic       clear,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_uartlite_responder.sv
// AXI4-lite UART-Lite responder: host byte streams in/out via RX/TX FIFOs; B two cycles after AW+W, R one cycle after AR.
// Holds AW/W/R until the master handshakes; RX host strobes never stall (dropped and flagged as overrun when full).
module axi_uartlite_responder
  import axi_uartlite_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [2:0]  axi_arprot,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data
);

  logic        bus_en;
  logic        aw_held, w_held, bvalid_q, rvalid_q;
  logic [1:0]  aw_reg;
  logic [7:0]  w_byte;
  logic        w_lane0;
  logic [31:0] rdata_q;
  logic        overrun;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_commit, reg_wr, ctrl_wr;
  logic tx_push, tx_pop, tx_clear, tx_empty, tx_full;
  logic rx_pop, rx_clear, rx_empty, rx_full;
  logic stat_rd, ovr_evt;
  logic [1:0]  rd_sel;
  logic [7:0]  rx_dout;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign unused_bits = ^{axi_awaddr[31:4], axi_awaddr[1:0], axi_awprot, axi_wdata[31:8],
                         axi_wstrb[3:1], axi_araddr[31:4], axi_araddr[1:0], axi_arprot};

  // bus_en keeps every ready low until the first edge after reset release.
  assign axi_awready = bus_en & ~aw_held & ~bvalid_q;
  assign axi_wready  = bus_en & ~w_held & ~bvalid_q;
  assign axi_arready = bus_en & ~rvalid_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_bresp   = AXI_RESP_OKAY;
  assign axi_rresp   = AXI_RESP_OKAY;

  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid & axi_wready;
  assign b_hs  = bvalid_q & axi_bready;
  assign ar_hs = axi_arvalid & axi_arready;
  assign r_hs  = rvalid_q & axi_rready;

  assign wr_commit = aw_held & w_held & ~bvalid_q;
  assign reg_wr    = wr_commit & w_lane0;
  assign tx_push   = reg_wr & (aw_reg == UART_TX);
  assign ctrl_wr   = reg_wr & (aw_reg == UART_CTRL);
  assign tx_clear  = ctrl_wr & w_byte[CTRL_CLR_TX];
  assign rx_clear  = ctrl_wr & w_byte[CTRL_CLR_RX];

  assign rd_sel  = axi_araddr[3:2];
  assign rx_pop  = ar_hs & (rd_sel == UART_RX) & ~rx_empty;
  assign stat_rd = ar_hs & (rd_sel == UART_STAT);
  assign tx_pop  = tx_valid & tx_ready;
  assign ovr_evt = rx_valid & rx_full & ~rx_pop & ~rx_clear;

  always_comb begin
    rd_val = '0;
    case (rd_sel)
      UART_RX:   rd_val = rx_empty ? 32'd0 : {24'd0, rx_dout};
      UART_STAT: rd_val = stat_word(~rx_empty, rx_full, tx_empty, tx_full, overrun);
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_en   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      aw_reg   <= '0;
      w_byte   <= '0;
      w_lane0  <= 1'b0;
      rdata_q  <= '0;
      overrun  <= 1'b0;
    end else begin
      bus_en <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_reg  <= axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        w_byte  <= axi_wdata[7:0];
        w_lane0 <= axi_wstrb[0];
      end
      if (wr_commit) bvalid_q <= 1'b1;
      if (b_hs) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
      if (r_hs) rvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end
      // A fresh overrun beats the clear-on-read of STAT.
      if (ovr_evt)      overrun <= 1'b1;
      else if (stat_rd) overrun <= 1'b0;
    end
  end

  axi_uartlite_responder_byte_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop),
    .clear (rx_clear),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

  axi_uartlite_responder_byte_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .din   (w_byte),
    .pop   (tx_pop),
    .clear (tx_clear),
    .dout  (tx_data),
    .empty (tx_empty),
    .full  (tx_full)
  );

  assign tx_valid = ~tx_empty;

endmodule
